// File: rtl/uart_rx_frame.sv
// UART frame receiver: majority-vote mid-bit sampling with parity and stop checks.
// Optional macro UART_RX_SYNC_EN adds a 2-flop input synchronizer (reset to 1) on RX_IN.
module uart_rx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int unsigned PW  = PRESCALE_W;
  localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [PW-1:0]         r_edge_cnt;
  logic [BCW-1:0]        r_bit_cnt;
  logic [PW-1:0]         r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_s0;
  logic                  r_s1;
  logic                  r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_err;
  logic                  w_rx;
  logic [PW-1:0]         w_half;
  logic                  w_at_s0;
  logic                  w_at_s1;
  logic                  w_at_s2;
  logic                  w_at_dec;
  logic                  w_bit_end;
  logic                  w_maj;
  logic                  w_start;
  logic                  w_done;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge CLK) begin
    if (RST) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], RX_IN};
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = RX_IN;
`endif

  assign w_half    = r_prescale >> 1;
  assign w_at_s0   = (r_edge_cnt == PW'(w_half - PW'(1)));
  assign w_at_s1   = (r_edge_cnt == w_half);
  assign w_at_s2   = (r_edge_cnt == PW'(w_half + PW'(1)));
  assign w_at_dec  = (r_edge_cnt == PW'(w_half + PW'(2)));
  assign w_bit_end = (r_edge_cnt == PW'(r_prescale - PW'(1)));
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and frame events
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_next  = S_START;
          w_start = 1'b1;
        end
      end
      S_START: begin
        if (w_at_dec && r_bit) w_next = S_IDLE;
        else if (w_bit_end)    w_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && (r_bit_cnt == BCW'(DATA_WIDTH - 1)))
          w_next = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_bit_end) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_at_dec) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Tick counter, bit index, config latch, samplers and data path
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_bit      <= 1'b1;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE)                    r_edge_cnt <= w_start ? PW'(1) : '0;
      else if ((w_next == S_IDLE) || w_bit_end) r_edge_cnt <= '0;
      else                                      r_edge_cnt <= r_edge_cnt + PW'(1);

      if (w_start) begin
        r_prescale <= Prescale;
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_par_err  <= 1'b0;
      end

      if (r_state == S_START)                r_bit_cnt <= '0;
      else if (r_state == S_DATA && w_bit_end) r_bit_cnt <= r_bit_cnt + BCW'(1);

      if (r_state != S_IDLE) begin
        if (w_at_s0) r_s0  <= w_rx;
        if (w_at_s1) r_s1  <= w_rx;
        if (w_at_s2) r_bit <= w_maj;
      end

      if (r_state == S_DATA && w_at_dec)
        r_shift <= {r_bit, r_shift[DATA_WIDTH-1:1]};
      if (r_state == S_PARITY && w_at_dec)
        r_par_err <= (r_bit != ((^r_shift) ^ r_par_typ));
    end
  end

  // Registered result pulses and output word
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid   <= w_done && r_bit && !r_par_err;
      parity_error <= w_done && r_par_err;
      stop_error   <= w_done && !r_bit;
      if (w_done && r_bit && !r_par_err) P_DATA <= r_shift;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: good frames, parity/stop errors, glitch, back-to-back, reset abort.
module tb_uart_rx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;
  int dv_cyc = 0;
  logic [7:0] dv_hist [0:15];
  int start_cyc;
  int start2;

  uart_rx_frame dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  always #5 CLK = ~CLK;

  // Cycle index: after posedge k, cyc == k
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor sampled mid-cycle
  always @(negedge CLK) begin
    if (!RST) begin
      if (data_valid) begin
        dv_hist[dv_cnt[3:0]] <= P_DATA;
        dv_cnt <= dv_cnt + 1;
        dv_cyc <= cyc;
      end
      if (parity_error) pe_cnt <= pe_cnt + 1;
      if (stop_error)   se_cnt <= se_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Drive the line to v for p cycles, starting just after a posedge
  task automatic hold(input logic v, input int p);
    RX_IN = v;
    repeat (p) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic with_par,
                            input logic par_bit, input logic stop_bit);
    start_cyc = cyc;
    hold(1'b0, p);
    for (int i = 0; i < 8; i++) hold(d[i], p);
    if (with_par) hold(par_bit, p);
    hold(stop_bit, p);
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pdata", 32'(P_DATA), 32'h0);
    chk("rst_dv",    32'(data_valid), 32'h0);
    chk("rst_pe",    32'(parity_error), 32'h0);
    chk("rst_se",    32'(stop_error), 32'h0);
    RST = 1'b0;
    hold(1'b1, 5);

    // Prescale 8, no parity, 0xA5
    Prescale = 6'd8; PAR_EN = 1'b0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 10);
    chk("t1_dv_cnt", 32'(dv_cnt), 32'd1);
    chk("t1_data",   32'(dv_hist[0]), 32'hA5);
    chk("t1_lat",    32'(dv_cyc - start_cyc), 32'd79);
    chk("t1_pe",     32'(pe_cnt), 32'd0);
    chk("t1_se",     32'(se_cnt), 32'd0);

    // Prescale 16, even parity, 0x3C with correct parity bit 0
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
    hold(1'b1, 20);
    chk("t2_dv_cnt", 32'(dv_cnt), 32'd2);
    chk("t2_data",   32'(dv_hist[1]), 32'h3C);
    chk("t2_lat",    32'(dv_cyc - start_cyc), 32'd171);
    chk("t2_pe",     32'(pe_cnt), 32'd0);

    // Same frame, wrong parity bit
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 20);
    chk("t3_pe",     32'(pe_cnt), 32'd1);
    chk("t3_dv_cnt", 32'(dv_cnt), 32'd2);
    chk("t3_pdata",  32'(P_DATA), 32'h3C);

    // Prescale 32, stop bit 0, 0xFF; the low stop tail re-enters START and is rejected
    Prescale = 6'd32; PAR_EN = 1'b0;
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 80);
    chk("t4_se",     32'(se_cnt), 32'd1);
    chk("t4_dv_cnt", 32'(dv_cnt), 32'd2);
    chk("t4_pe",     32'(pe_cnt), 32'd1);

    // Start glitch then a good frame
    Prescale = 6'd8;
    hold(1'b0, 2);
    hold(1'b1, 20);
    chk("t5_glitch_dv", 32'(dv_cnt), 32'd2);
    chk("t5_glitch_se", 32'(se_cnt), 32'd1);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 10);
    chk("t5_dv_cnt", 32'(dv_cnt), 32'd3);
    chk("t5_data",   32'(dv_hist[2]), 32'h5A);

    // Back-to-back frames, then reset during a third frame
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1);
    start2 = cyc;
    send_frame(8'h80, 8, 1'b0, 1'b0, 1'b1);
    hold(1'b0, 12);
    RST = 1'b1;
    RX_IN = 1'b1;
    @(posedge CLK);
    #1;
    chk("t6_rst_pdata", 32'(P_DATA), 32'h0);
    chk("t6_rst_dv",    32'(data_valid), 32'h0);
    chk("t6_rst_pe",    32'(parity_error), 32'h0);
    chk("t6_rst_se",    32'(stop_error), 32'h0);
    RST = 1'b0;
    hold(1'b1, 120);
    chk("t6_dv_cnt", 32'(dv_cnt), 32'd5);
    chk("t6_data0",  32'(dv_hist[3]), 32'h01);
    chk("t6_data1",  32'(dv_hist[4]), 32'h80);
    chk("t6_lat2",   32'(dv_cyc - start2), 32'd79);
    chk("t6_pe",     32'(pe_cnt), 32'd1);
    chk("t6_se",     32'(se_cnt), 32'd1);
    chk("t6_pdata",  32'(P_DATA), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receiver: the receive-side counterpart of the system's UART transmitter, whose frame is start bit, data bits LSB first, optional parity bit, stop bit.
- Runs on the oversampling clock, one CLK edge per sample tick. Recovers each frame by majority-vote mid-bit sampling.
- Checks parity and stop bit, then presents parallel data with a one-cycle valid pulse to the system-side data synchronizer.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_W, 6, width of the Prescale port.

Ports:
- CLK  input  1  oversampling clock.
- RST  input  1  reset, synchronous and active-high.
- RX_IN  input  1  serial line; idle level 1.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Prescale  input  PRESCALE_W  ticks per bit; legal values are even, 8..32.
- P_DATA  output  DATA_WIDTH  received data word.
- data_valid  output  1  one-cycle pulse, frame good.
- parity_error  output  1  one-cycle pulse, parity mismatch.
- stop_error  output  1  one-cycle pulse, stop bit sampled 0.

Behaviour:
- Reset: one clock and one reset only. Reset is synchronous and active-high; RST is sampled on the CLK rising edge.
  - On RST=1: state=IDLE, edge_cnt=0, bit_cnt=0, P_DATA=0, data_valid=0, parity_error=0, stop_error=0.
  - RST aborts any frame in progress with no pulses emitted.
- States: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - edge_cnt counts 0..Prescale-1 within a bit. At Prescale-1 it wraps to 0 and the bit position advances.
  - bit_cnt indexes data bits 0..DATA_WIDTH-1.
- Start detection: in IDLE, the first cycle RX_IN=0 is edge_cnt=0 of the start bit.
  - Next state START.
  - PAR_EN, PAR_TYP and Prescale are latched in that cycle; changes mid-frame are ignored.
- Sampling: RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1, where P is the latched Prescale.
  - Bit value = majority of the 3 samples, registered at edge_cnt = P/2+1.
  - The value is usable from edge_cnt = P/2+2.
- START: at edge_cnt = P/2+2, a majority of 1 is a glitch → IDLE immediately, no pulses. Otherwise remain in START until the bit ends, then go to DATA.
- DATA: the majority bit is shifted into an internal register LSB first.
  - After bit DATA_WIDTH-1 ends: go to PARITY if PAR_EN=1, else STOP.
- PARITY: the majority bit is compared with the expected value, XOR of the data bits (even) or its inverse (odd).
  - The mismatch is held internally; the frame continues to STOP.
- STOP: decision at edge_cnt = P/2+2; the next state is IDLE in the same cycle, so back-to-back frames are caught.
  - Outputs register on the following edge.
  - If stop=1 and no parity error: P_DATA ← data, data_valid=1.
  - If parity error: parity_error=1, data_valid=0, P_DATA unchanged.
  - If stop=0: stop_error=1, data_valid=0, P_DATA unchanged.
  - Both errors may pulse together.
- Pulses: each pulse lasts exactly 1 cycle. P_DATA holds its value until the next good frame.
- Latency: for a frame with no parity bit, data_valid rises (DATA_WIDTH+1)*P + P/2+3 cycles after the start-edge cycle, with no RX_SYNC_EN.
- RX_IN low in IDLE after a stop error restarts detection normally (a line held low re-enters START).

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer, reset to 1, before all logic. All timing above shifts +2 cycles relative to the raw RX_IN.
- Undefined: RX_IN is used directly; the source is assumed to be synchronous to CLK.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 → one data_valid pulse, P_DATA=0xA5, at start+79 cycles; no error pulses.
- Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C, parity bit 0 → data_valid=1, P_DATA=0x3C.
- Same frame with parity bit 1 → parity_error pulse, data_valid=0, P_DATA keeps its previous value.
- Prescale=32, stop bit driven 0, data 0xFF → stop_error pulse, no data_valid.
- Start glitch: RX_IN low for 2 ticks at Prescale=8 → return to IDLE, no pulses; then a valid frame 0x5A is received correctly.
- Back-to-back frames 0x01 and 0x80 at Prescale=8 with no idle gap, plus RST=1 asserted mid-frame on a third frame → two valid pulses with correct data; the third frame produces no pulse and all outputs read 0 after reset.
